cyber_player: RTL and testbench

- Computer opponent for the tug-of-war game; sits upstream of the playfield and victory logic, in place of one human input handler.
- Emits single-cycle "press" pulses at a pseudo-random rate set by a difficulty threshold from the switches.
- Uses a 10-bit XNOR LFSR sampled on a prescaled tick, plus a cooldown so presses are never back-to-back ticks.
- Output is drop-in compatible with the L/R pulse convention: one cycle high per press.

---
 rtl/tow_pkg.sv | 23 ++
 rtl/cyber_player_lfsr10.sv | 24 ++
 rtl/cyber_player.sv | 106 ++++++++++
 tb/tb_cyber_player.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war computer opponent.
// Provides LFSR width/taps, FSM state type and the LFSR step function.
package tow_pkg;

  localparam int LFSR_W_C = 10;
  localparam int TAP_HI   = 9;
  localparam int TAP_LO   = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    COOL
  } cp_state_t;

  // x^10 + x^7 + 1, XNOR form: all-ones is the lock-up value,
  // so the all-zero reset value sits on the 1023-long cycle.
  function automatic logic [LFSR_W_C-1:0] lfsr_next(
    input logic [LFSR_W_C-1:0] v
  );
    return {v[LFSR_W_C-2:0], ~(v[TAP_HI] ^ v[TAP_LO])};
  endfunction

endpackage

// File: rtl/cyber_player_lfsr10.sv
// 10-bit XNOR LFSR that steps only when adv is high.
// Ports: clk, reset (sync, active-low), adv (step), q (value).
module lfsr10
  import tow_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                adv,
  output logic [LFSR_W_C-1:0] q
);

  logic [LFSR_W_C-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= '0;
    end else if (adv) begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/cyber_player.sv
// Computer opponent: one-cycle press pulses at an LFSR-driven rate.
// Ports: clk, reset (sync, active-low), enable, threshold -> press, lfsr_q.
module cyber_player
  import tow_pkg::*;
#(
  parameter int unsigned LFSR_W   = 10,
  parameter int unsigned PRESCALE = 25_000_000,
  parameter int unsigned COOLDOWN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [LFSR_W-1:0] threshold,
  output logic              press,
  output logic [LFSR_W-1:0] lfsr_q
);

  localparam logic [31:0] PS_LAST = 32'(PRESCALE - 1);
  localparam logic [31:0] CD_LOAD = 32'(COOLDOWN);

  cp_state_t           r_state;
  cp_state_t           w_state_nxt;
  logic [31:0]         r_cnt;
  logic [31:0]         r_cool;
  logic [31:0]         w_cool_nxt;
  logic                r_press;
  logic                w_press_nxt;
  logic                w_tick;
  logic                w_adv;
  logic [LFSR_W_C-1:0] w_q;

  // A tick is cancelled by enable dropping in the same cycle.
  assign w_tick = (r_state != IDLE) && (r_cnt == PS_LAST);
  assign w_adv  = w_tick && enable;

  lfsr10 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .adv   (w_adv),
    .q     (w_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cool  <= '0;
      r_press <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cool  <= w_cool_nxt;
      r_press <= w_press_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!enable || r_state == IDLE) begin
      r_cnt <= '0;
    end else if (r_cnt == PS_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cool_nxt  = r_cool;
    w_press_nxt = 1'b0;
    if (!enable) begin
      w_state_nxt = IDLE;
      w_cool_nxt  = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = RUN;
        end
        RUN: begin
          if (w_tick && (threshold > w_q)) begin
            w_press_nxt = 1'b1;
            if (CD_LOAD != 32'd0) begin
              w_state_nxt = COOL;
              w_cool_nxt  = CD_LOAD;
            end
          end
        end
        COOL: begin
          if (w_tick) begin
            w_cool_nxt = r_cool - 32'd1;
            if (r_cool <= 32'd1) begin
              w_state_nxt = RUN;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign press  = r_press;
  assign lfsr_q = w_q;

endmodule

// File: tb/tb_cyber_player.sv
// Randomised bench for cyber_player against a tick-level model.
// Four instances with different PRESCALE/COOLDOWN share one stimulus.
module tb_cyber_player;

  localparam int N = 4;

  function automatic int ps_of(input int i);
    case (i)
      0: return 1;
      1: return 4;
      2: return 4;
      default: return 3;
    endcase
  endfunction

  function automatic int cd_of(input int i);
    case (i)
      0: return 0;
      1: return 0;
      2: return 1;
      default: return 2;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [9:0] thr = '0;
  logic [N-1:0] press;
  logic [9:0] q [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    cyber_player #(
      .LFSR_W   (10),
      .PRESCALE (ps_of(g)),
      .COOLDOWN (cd_of(g))
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .threshold (thr),
      .press     (press[g]),
      .lfsr_q    (q[g])
    );
  end

  // Model: cycles since play started, ticks still to skip, LFSR value.
  bit         m_run   [N];
  int         m_cyc   [N];
  int         m_skip  [N];
  logic [9:0] m_lfsr  [N];
  bit         m_press [N];

  function automatic logic [9:0] step(input logic [9:0] v);
    int b;
    b = (((v >> 9) & 1) == ((v >> 6) & 1)) ? 1 : 0;
    return 10'(((int'(v) << 1) & 1023) | b);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      bit tk;
      if (!reset) begin
        m_run[i] = 0; m_cyc[i] = 0; m_skip[i] = 0;
        m_lfsr[i] = '0; m_press[i] = 0;
      end else if (!enable) begin
        m_run[i] = 0; m_cyc[i] = 0; m_skip[i] = 0;
        m_press[i] = 0;
      end else if (!m_run[i]) begin
        m_run[i] = 1; m_cyc[i] = 0; m_press[i] = 0;
      end else begin
        tk = ((m_cyc[i] + 1) % ps_of(i)) == 0;
        m_cyc[i]++;
        m_press[i] = tk && m_skip[i] == 0 && thr > m_lfsr[i];
        if (tk) begin
          if (m_skip[i] > 0) m_skip[i]--;
          else if (m_press[i]) m_skip[i] = cd_of(i);
          m_lfsr[i] = step(m_lfsr[i]);
        end
      end
    end
  end

  int vec = 0;
  int bad = 0;
  bit chk = 0;

  always @(negedge clk) begin
    if (chk) begin
      for (int i = 0; i < N; i++) begin
        vec++;
        if (press[i] !== m_press[i] || q[i] !== m_lfsr[i]) begin
          bad++;
          $display("FAIL model[%0d] t=%0t press=%b q=%0d exp press=%b q=%0d",
                   i, $time, press[i], q[i], m_press[i], m_lfsr[i]);
        end
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic rst_pulse();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int seq [9] = '{0, 1, 3, 7, 15, 31, 63, 127, 254};
    int first, n1, n2, r;

    reset = 1'b0; enable = 1'b1; thr = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("rst_press", int'(press[i]), 0);
      check("rst_q", int'(q[i]), 0);
    end
    chk = 1;

    reset = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("seq_q", int'(q[0]), seq[k-1]);
      check("seq_press", int'(press[0]), 0);
    end

    thr = 10'd1023;
    rst_pulse();
    first = -1; n1 = 0; n2 = 0;
    for (int k = 1; k <= 401; k++) begin
      @(negedge clk);
      if (press[1]) begin
        n1++;
        if (first < 0) first = k;
      end
      if (press[2]) n2++;
    end
    check("first_press", first, 5);
    check("max_presses", n1, 100);
    check("cool_presses", n2, 50);

    thr = 10'd127;
    rst_pulse();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("cmp_bound", int'(press[0]), (k >= 2 && k <= 8) ? 1 : 0);
    end

    thr = 10'd1023;
    rst_pulse();
    repeat (4) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("drop_press", int'(press[1]), 0);
    check("drop_q", int'(q[1]), 0);
    enable = 1'b1;
    repeat (12) @(negedge clk);

    rst_pulse();
    repeat (6) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midcool_q", int'(q[2]), 0);
    check("midcool_press", int'(press[2]), 0);
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("rerun_press", int'(press[2]), (k == 5) ? 1 : 0);
    end

    repeat (3000) begin
      @(negedge clk);
      reset  = ($urandom_range(63) != 0);
      enable = ($urandom_range(15) != 0);
      r = $urandom_range(7);
      if (r == 0)      thr = 10'd0;
      else if (r == 1) thr = 10'd1023;
      else             thr = 10'($urandom);
    end
    @(negedge clk);
    chk = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
